bcd_countdown: RTL
==================

Name: bcd_countdown

Overview:
Two-digit BCD countdown timer covering 00-59. It is the down-counting counterpart of the team's up-counting seconds timer and uses the same digit outputs, nums_0 (ones) and nums_1 (tens). A preset value is loaded and then decremented once per prescaled tick, with start, pause and resume control. When the count reaches 00 the block issues a one-cycle bout pulse and holds at 00.

Parameters:
TICK_DIV, 10, clk cycles per count step (>=2)

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
load  input  1  single-cycle strobe; capture load_ones/load_tens
load_ones  input  4  preset ones digit
load_tens  input  3  preset tens digit
start  input  1  level/strobe; begin or resume counting
pause  input  1  level/strobe; suspend counting
nums_0  output  4  current ones digit, BCD 0-9
nums_1  output  3  current tens digit, 0-5
running  output  1  high while state is RUN
bout  output  1  one-cycle pulse when count reaches 00

Behaviour:
- Reset (rstn low, asynchronous):
  - nums_0=0, nums_1=0, running=0, bout=0.
  - Prescaler=0, state=IDLE.
- States: IDLE, RUN, PAUSE, DONE. running = (state==RUN), registered.
- Control priority, evaluated every edge: load > pause > start.
- load (any state):
  - Digits <= preset. Clamp load_ones>9 to 9 and load_tens>5 to 5.
  - Prescaler <= 0, state <= IDLE, bout <= 0.
- IDLE:
  - start with value != 00 -> RUN, prescaler <= 0.
  - start with value == 00 is ignored.
  - pause is ignored.
- RUN:
  - Prescaler increments each cycle.
  - When prescaler == TICK_DIV-1: prescaler <= 0 and one decrement occurs (tick).
  - pause (including pause and start together) -> PAUSE, prescaler frozen, no tick that cycle.
- PAUSE:
  - Digits and prescaler hold.
  - start -> RUN. Resume continues from the frozen prescaler value, so no partial-tick time is lost.
- Decrement, on tick:
  - nums_0 > 0: nums_0 - 1.
  - nums_0 == 0 and nums_1 > 0: nums_0 <= 9, nums_1 - 1 (borrow).
- Terminal:
  - When a tick produces 00 (value was 01), on that same edge: state <= DONE, running <= 0, bout <= 1.
  - bout returns to 0 on the next edge.
- DONE:
  - Digits hold 00, prescaler holds 0.
  - start and pause are ignored. Only load or reset leave DONE.
- Latency:
  - Start-to-first-decrement is exactly TICK_DIV edges after the edge that entered RUN.
  - The full count from preset N (N = 10*tens + ones) takes N*TICK_DIV cycles of RUN.
- Digits never leave their legal range; 9 is the only value written to nums_0 on borrow.
- Reset mid-count takes effect immediately and asynchronously; no bout is produced.
- load during RUN aborts the count with no bout pulse.

Test Plan:
1. TICK_DIV=4, reset -> all outputs 0. Then load 2/5, start -> running=1. nums 25->24 after 4 edges, ->23 after 8 edges.
2. Borrow: load tens=1, ones=0, start -> after one tick nums_1=0, nums_0=9. Continues down to 00 with bout high for exactly 1 cycle at the 10th tick (40 edges). Then running=0 and digits hold 00 for 20 more cycles.
3. Pause/resume: load 0/5, start, pause after 2 edges -> digits stay 05 for 10 cycles. start -> 04 appears 2 edges after resume (prescaler preserved).
4. Clamp and ignore: load ones=12, tens=7 -> nums 59. In IDLE with value 00, start -> running stays 0, no bout. start and pause together in RUN -> PAUSE.
5. Abort: load 3/0, start, pulse rstn low mid-count -> asynchronous clear to 00/IDLE, bout never asserted. Separately, load 0/8 during RUN -> value 08, IDLE, running=0, no bout.
6. DONE lock: after bout, assert start for 5 cycles -> digits 00, running 0. Then load 0/2, start -> counts 02, 01, 00 with one further bout pulse.

Source files
------------

// File: rtl/bcd_countdown.sv
// Two-digit BCD countdown timer (00-59) with prescaled decrement, start/pause/resume
// control, a one-cycle bout pulse on reaching 00, and hold at 00 until reloaded.
module bcd_countdown #(
    parameter int unsigned TICK_DIV = 10
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       load,
    input  logic [3:0] load_ones,
    input  logic [2:0] load_tens,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] nums_0,
    output logic [2:0] nums_1,
    output logic       running,
    output logic       bout
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0] ONES_MAX = 4'd9;
    localparam logic [2:0] TENS_MAX = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      ones_q, ones_d;
    logic [2:0]      tens_q, tens_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            running_q, running_d;
    logic            bout_q, bout_d;

    logic            is_zero_c;
    logic            is_one_c;
    logic            tick_c;

    assign is_zero_c = (ones_q == 4'd0) && (tens_q == 3'd0);
    assign is_one_c  = (ones_q == 4'd1) && (tens_q == 3'd0);
    assign tick_c    = (presc_q == PRESC_LAST);

    // State, digit, prescaler and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            ones_q    <= 4'd0;
            tens_q    <= 3'd0;
            presc_q   <= '0;
            running_q <= 1'b0;
            bout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            bout_q    <= bout_d;
        end
    end

    // Next-state logic; control priority is load > pause > start
    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        presc_d = presc_q;
        bout_d  = 1'b0;

        if (load) begin
            ones_d  = (load_ones > ONES_MAX) ? ONES_MAX : load_ones;
            tens_d  = (load_tens > TENS_MAX) ? TENS_MAX : load_tens;
            presc_d = '0;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!pause && start && !is_zero_c) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (tick_c) begin
                        presc_d = '0;
                        if (ones_q != 4'd0) begin
                            ones_d = ones_q - 4'd1;
                        end else begin
                            ones_d = ONES_MAX;
                            tens_d = tens_q - 3'd1;
                        end
                        // Value 01 decrements to 00: finish and pulse bout on this edge
                        if (is_one_c) begin
                            state_d = DONE;
                            bout_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (!pause && start) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    presc_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        running_d = (state_d == RUN);
    end

    assign nums_0  = ones_q;
    assign nums_1  = tens_q;
    assign running = running_q;
    assign bout    = bout_q;

endmodule
